// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared widths and standard half-period divisors for the clock divider
package clkdiv_pkg;

  localparam int unsigned CLKDIV_CNT_W = 26;

  // Half-period counts at 50 MHz.
  localparam int unsigned DIV_100HZ = 250000;
  localparam int unsigned DIV_1KHZ  = 25000;
  localparam int unsigned DIV_1HZ   = 25000000;

endpackage

// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - control/status bundle of clock_divider_prog (sync_clr only with CLKDIV_SYNC_CLR_EN)
interface clkdiv_if import clkdiv_pkg::*; #(
  parameter int unsigned CNT_W = CLKDIV_CNT_W
) ();

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
`ifdef CLKDIV_SYNC_CLR_EN
  logic             sync_clr;
`endif
  logic             clk_out;
  logic             tick_half;
  logic             tick_full;
  logic             div_pending;

  modport master (
    output en, div_in, div_load,
`ifdef CLKDIV_SYNC_CLR_EN
    output sync_clr,
`endif
    input  clk_out, tick_half, tick_full, div_pending
  );

  modport slave (
    input  en, div_in, div_load,
`ifdef CLKDIV_SYNC_CLR_EN
    input  sync_clr,
`endif
    output clk_out, tick_half, tick_full, div_pending
  );

endinterface

// File: rtl/clkdiv_tc_counter.sv
// rtl/clkdiv_tc_counter.sv - enable-qualified half-period counter with zero-guarded terminal count
module clkdiv_tc_counter import clkdiv_pkg::*; #(
  parameter int unsigned CNT_W = CLKDIV_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] eff;

  // A zero divisor behaves as one so the counter can never run past TC.
  assign eff  = (div_i == '0) ? CNT_W'(1) : div_i;
  assign tc_o = en_i & (cnt_q == eff - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable divide-by-2*div clock and tick generator
// Optional synchronous phase clear via CLKDIV_SYNC_CLR_EN.
module clock_divider_prog import clkdiv_pkg::*; #(
  parameter int unsigned CNT_W       = CLKDIV_CNT_W,
  parameter int unsigned DIV_DEFAULT = DIV_100HZ
) (
  input  logic     CLK_50_MHz,
  input  logic     reset,
  clkdiv_if.slave  bus
);

  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_half_q, tick_half_d;
  logic             tick_full_q, tick_full_d;
  logic             tc;
  logic             sync_clr;

`ifdef CLKDIV_SYNC_CLR_EN
  assign sync_clr = bus.sync_clr;
`else
  assign sync_clr = 1'b0;
`endif

  clkdiv_tc_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i (CLK_50_MHz),
    .rst_i (reset),
    .en_i  (bus.en),
    .clr_i (sync_clr),
    .div_i (act_div_q),
    .tc_o  (tc)
  );

  always_comb begin
    act_div_d   = act_div_q;
    pend_div_d  = pend_div_q;
    pending_d   = pending_q;
    clk_out_d   = clk_out_q;
    tick_half_d = 1'b0;
    tick_full_d = 1'b0;

    // Divisor changes only where the counter restarts, so a half period is never cut short.
    if (sync_clr || tc) begin
      pending_d = 1'b0;
      if (bus.div_load) begin
        act_div_d = bus.div_in;
      end else if (pending_q) begin
        act_div_d = pend_div_q;
      end
    end else if (bus.div_load) begin
      pend_div_d = bus.div_in;
      pending_d  = 1'b1;
    end

    if (sync_clr) begin
      clk_out_d = 1'b0;
    end else if (tc) begin
      clk_out_d   = ~clk_out_q;
      tick_half_d = 1'b1;
      tick_full_d = clk_out_q;
    end
  end

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      act_div_q   <= CNT_W'(DIV_DEFAULT);
      pend_div_q  <= '0;
      pending_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_half_q <= 1'b0;
      tick_full_q <= 1'b0;
    end else begin
      act_div_q   <= act_div_d;
      pend_div_q  <= pend_div_d;
      pending_q   <= pending_d;
      clk_out_q   <= clk_out_d;
      tick_half_q <= tick_half_d;
      tick_full_q <= tick_full_d;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.tick_half   = tick_half_q;
  assign bus.tick_full   = tick_full_q;
  assign bus.div_pending = pending_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed self-checking bench for clock_divider_prog (DIV_DEFAULT=3)
module tb_clock_divider_prog;
  import clkdiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  clkdiv_if #(.CNT_W(CLKDIV_CNT_W)) bus ();

  clock_divider_prog #(.CNT_W(CLKDIV_CNT_W), .DIV_DEFAULT(3)) dut (
    .CLK_50_MHz (clk),
    .reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Observed vector is {clk_out, tick_half, tick_full, div_pending}.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.clk_out, bus.tick_half, bus.tick_full, bus.div_pending};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.div_in   = '0;
    bus.div_load = 1'b0;
`ifdef CLKDIV_SYNC_CLR_EN
    bus.sync_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 4'b0000);
    rst = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      cyc($sformatf("t1_edge%0d", k),
          {((k / 3) % 2) == 1, (k % 3) == 0, (k % 6) == 0, 1'b0});
    end

    cyc("t2_cnt1", 4'b0000);
    bus.div_load = 1'b1;
    bus.div_in   = 5;
    cyc("t2_pending", 4'b0001);
    bus.div_load = 1'b0;
    cyc("t2_old_half_end", 4'b1100);
    for (int k = 0; k < 4; k++) cyc("t2_new_half_hold", 4'b1000);
    cyc("t2_new_half_end", 4'b0110);

    for (int k = 0; k < 4; k++) cyc("t3_wait_tc", 4'b0000);
    bus.div_load = 1'b1;
    bus.div_in   = 0;
    cyc("t3_load_on_tc", 4'b1100);
    bus.div_load = 1'b0;
    cyc("t3_div0_a", 4'b0110);
    cyc("t3_div0_b", 4'b1100);
    cyc("t3_div0_c", 4'b0110);
    bus.div_load = 1'b1;
    bus.div_in   = 3;
    cyc("t3_restore", 4'b1100);
    bus.div_load = 1'b0;
    cyc("t3_div3_a", 4'b1000);
    cyc("t3_div3_b", 4'b1000);
    cyc("t3_div3_tc", 4'b0110);

    cyc("t4_cnt1", 4'b0000);
    bus.en = 1'b0;
    cyc("t4_frozen1", 4'b0000);
    bus.div_load = 1'b1;
    bus.div_in   = 3;
    cyc("t4_load_while_frozen", 4'b0001);
    bus.div_load = 1'b0;
    cyc("t4_frozen3", 4'b0001);
    cyc("t4_frozen4", 4'b0001);
    bus.en = 1'b1;
    cyc("t4_resume_no_tc", 4'b0001);
    cyc("t4_resume_tc", 4'b1100);

    bus.div_load = 1'b1;
    bus.div_in   = 7;
    cyc("t5_pending_set", 4'b1001);
    bus.div_load = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t5_async_reset", 4'b0000);
    #2 rst = 1'b0;
    cyc("t5_r1", 4'b0000);
    cyc("t5_r2", 4'b0000);
    cyc("t5_r3_tc", 4'b1100);
    cyc("t5_r4", 4'b1000);
    cyc("t5_r5", 4'b1000);
    cyc("t5_r6_tc", 4'b0110);

`ifdef CLKDIV_SYNC_CLR_EN
    cyc("t6_c1", 4'b0000);
    cyc("t6_c2", 4'b0000);
    cyc("t6_tc", 4'b1100);
    bus.div_load = 1'b1;
    bus.div_in   = 4;
    cyc("t6_pending", 4'b1001);
    bus.div_load = 1'b0;
    cyc("t6_cnt2", 4'b1001);
    bus.sync_clr = 1'b1;
    cyc("t6_cleared", 4'b0000);
    bus.sync_clr = 1'b0;
    for (int k = 0; k < 3; k++) cyc("t6_div4_hold", 4'b0000);
    cyc("t6_div4_tc", 4'b1100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
